// File: rtl/perceptron_trainer.sv
// Perceptron predictor trainer: queues resolved-branch updates, reads the weight row,
// and writes back a saturated +/-1 update whenever the prediction was wrong or weak.
module perceptron_trainer #(
    parameter int GHR_SIZE   = 12,
    parameter int THETA      = 37,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [31:0]             upd_PC,
    input  logic                    upd_dir,
    input  logic [GHR_SIZE-1:0]     upd_ghr,
    output logic [5:0]              rd_addr,
    input  logic [8*GHR_SIZE-1:0]   rd_data,
    output logic                    wr_en,
    output logic [5:0]              wr_addr,
    output logic [8*GHR_SIZE-1:0]   wr_data,
    output logic [3*GHR_SIZE-1:0]   wr_hob,
    output logic [3*GHR_SIZE-1:0]   wr_hob_c,
    input  logic                    stall,
    output logic                    busy,
    output logic [31:0]             train_count
);

    localparam int SUM_W = $clog2(128 * GHR_SIZE + 1) + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {INIT, IDLE, READ, CALC, WRITE} state_t;

    function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
        if (v > 10'sd127)       return 8'sh7f;
        else if (v < -10'sd128) return 8'sh80;
        else                    return v[7:0];
    endfunction

    function automatic logic signed [7:0] step_w(input logic signed [7:0] w, input logic up);
        logic signed [9:0] wx;
        wx = {{2{w[7]}}, w};
        return sat8(up ? wx + 10'sd1 : wx - 10'sd1);
    endfunction

    function automatic logic [2:0] neg_hob(input logic signed [7:0] w);
        logic signed [9:0] wx;
        logic signed [7:0] n;
        wx = {{2{w[7]}}, w};
        n  = sat8(-wx);
        return n[7:5];
    endfunction

    function automatic logic signed [SUM_W-1:0] dot(input logic [8*GHR_SIZE-1:0] row,
                                                    input logic [GHR_SIZE-1:0]   ghr);
        logic signed [SUM_W-1:0] acc;
        logic signed [SUM_W-1:0] term;
        acc = '0;
        for (int i = 0; i < GHR_SIZE; i++) begin
            term = {{(SUM_W-8){row[8*i+7]}}, row[8*i +: 8]};
            acc  = ghr[i] ? acc + term : acc - term;
        end
        return acc;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t                   state;
    logic                     init_run;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         q_count;
    logic [5:0]               q_idx [FIFO_DEPTH];
    logic                     q_dir [FIFO_DEPTH];
    logic [GHR_SIZE-1:0]      q_ghr [FIFO_DEPTH];
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     push;
    logic                     pop;
    logic                     write_fire;
    logic                     req_dir_p1;
    logic [GHR_SIZE-1:0]      req_ghr_p1;
    logic signed [SUM_W-1:0]  sum_p1;
    logic [SUM_W-1:0]         sum_abs_p1;
    logic                     train_p1;
    logic [8*GHR_SIZE-1:0]    row_new;
    logic [3*GHR_SIZE-1:0]    hob_new;
    logic [3*GHR_SIZE-1:0]    hobc_new;
    logic [8*GHR_SIZE-1:0]    row_p2;
    logic [3*GHR_SIZE-1:0]    hob_p2;
    logic [3*GHR_SIZE-1:0]    hobc_p2;
    logic                     unused_pc_bits;

    assign unused_pc_bits = ^{upd_PC[31:8], upd_PC[1:0]};

    assign fifo_empty = (q_count == '0);
    assign fifo_full  = (q_count == CNT_W'(FIFO_DEPTH));
    assign upd_ready  = !fifo_full && (state != INIT);
    assign push       = upd_valid && upd_ready;
    assign write_fire = (state == WRITE) && !stall;
    assign pop        = !fifo_empty && ((state == IDLE) || write_fire);
    assign busy       = (state != IDLE) || !fifo_empty;

    // CALC stage: rd_data holds the row addressed during READ
    assign sum_p1     = dot(rd_data, req_ghr_p1);
    assign sum_abs_p1 = sum_p1[SUM_W-1] ? -sum_p1 : sum_p1;
    assign train_p1   = (req_dir_p1 != ~sum_p1[SUM_W-1]) || (sum_abs_p1 <= SUM_W'(THETA));

    always_comb begin
        row_new  = '0;
        hob_new  = '0;
        hobc_new = '0;
        for (int i = 0; i < GHR_SIZE; i++) begin
            row_new[8*i +: 8]  = step_w(rd_data[8*i +: 8], req_dir_p1 == req_ghr_p1[i]);
            hob_new[3*i +: 3]  = row_new[8*i+5 +: 3];
            hobc_new[3*i +: 3] = neg_hob(row_new[8*i +: 8]);
        end
    end

    // WRITE stage: the sweep writes zero rows, training writes the registered update
    assign wr_en    = ((state == INIT) && init_run) || write_fire;
    assign wr_data  = (state == WRITE) ? row_p2  : '0;
    assign wr_hob   = (state == WRITE) ? hob_p2  : '0;
    assign wr_hob_c = (state == WRITE) ? hobc_p2 : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= INIT;
            init_run    <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            train_count <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_count     <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop) begin
                rd_ptr  <= ptr_next(rd_ptr);
                rd_addr <= q_idx[rd_ptr];
            end
            if (push && !pop)      q_count <= q_count + 1'b1;
            else if (pop && !push) q_count <= q_count - 1'b1;

            case (state)
                INIT: begin
                    // first cycle after release only arms the sweep so wr_en never rises during reset
                    if (!init_run) begin
                        init_run <= 1'b1;
                    end else begin
                        wr_addr <= wr_addr + 6'd1;
                        if (wr_addr == 6'd63) state <= IDLE;
                    end
                end
                IDLE:  if (!fifo_empty) state <= READ;
                READ:  state <= CALC;
                CALC: begin
                    if (train_p1) begin
                        state   <= WRITE;
                        wr_addr <= rd_addr;
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    if (!stall) begin
                        train_count <= train_count + 32'd1;
                        state       <= fifo_empty ? IDLE : READ;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[wr_ptr] <= upd_PC[7:2];
            q_dir[wr_ptr] <= upd_dir;
            q_ghr[wr_ptr] <= upd_ghr;
        end
        if (pop) begin
            req_dir_p1 <= q_dir[rd_ptr];
            req_ghr_p1 <= q_ghr[rd_ptr];
        end
        if (state == CALC) begin
            row_p2  <= row_new;
            hob_p2  <= hob_new;
            hobc_p2 <= hobc_new;
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: weight RAM model, row-level reference model of the
// training rule, directed corner cases and a randomized request/stall run.
`timescale 1ns/1ps
module tb_perceptron_trainer;

    localparam int G  = 12;
    localparam int TH = 37;

    logic           clk = 1'b0;
    logic           reset;
    logic           upd_valid;
    logic           upd_ready;
    logic [31:0]    upd_PC;
    logic           upd_dir;
    logic [G-1:0]   upd_ghr;
    logic [5:0]     rd_addr;
    logic [8*G-1:0] rd_data;
    logic           wr_en;
    logic [5:0]     wr_addr;
    logic [8*G-1:0] wr_data;
    logic [3*G-1:0] wr_hob;
    logic [3*G-1:0] wr_hob_c;
    logic           stall;
    logic           busy;
    logic [31:0]    train_count;

    always #5 clk = ~clk;

    perceptron_trainer #(.GHR_SIZE(G), .THETA(TH), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_PC(upd_PC), .upd_dir(upd_dir), .upd_ghr(upd_ghr), .rd_addr(rd_addr),
        .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_hob(wr_hob), .wr_hob_c(wr_hob_c), .stall(stall), .busy(busy),
        .train_count(train_count)
    );

    // weight RAM: registered read, plus a preload port for seeding rows
    logic [8*G-1:0] mem [64];
    logic           pl_en;
    logic [5:0]     pl_idx;
    logic [8*G-1:0] pl_row;

    always @(posedge clk) begin
        if (wr_en)      mem[wr_addr] <= wr_data;
        else if (pl_en) mem[pl_idx]  <= pl_row;
        rd_data <= mem[rd_addr];
    end

    typedef struct packed {
        logic [5:0]     addr;
        logic [8*G-1:0] data;
        logic [3*G-1:0] hob;
        logic [3*G-1:0] hobc;
    } wr_t;

    int       ref_w [64][G];
    wr_t      exp_q [$];
    wr_t      mon_e;
    int       exp_done;
    int       n_vec = 0;
    int       n_err = 0;
    logic     mon_en;
    logic     saw_ready_low;
    logic     rnd_done;
    logic [5:0]     last_addr;
    logic [3*G-1:0] last_hob;
    logic [3*G-1:0] last_hobc;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 64; r++)
            for (int i = 0; i < G; i++) ref_w[r][i] = 0;
        exp_q.delete();
        exp_done = 0;
    endtask

    // reference: dot product with signed ints, then clamp each weight to a byte
    task automatic model_accept(input int idx, input logic dir, input logic [G-1:0] ghr);
        int   sum, mag, nw, nc;
        logic pred;
        logic [7:0] b, bc;
        wr_t  e;
        sum = 0;
        for (int i = 0; i < G; i++) sum += ghr[i] ? ref_w[idx][i] : -ref_w[idx][i];
        mag  = (sum < 0) ? -sum : sum;
        pred = (sum >= 0);
        if ((pred != dir) || (mag <= TH)) begin
            e.addr = idx[5:0];
            for (int i = 0; i < G; i++) begin
                nw = ref_w[idx][i] + ((dir == ghr[i]) ? 1 : -1);
                if (nw > 127)  nw = 127;
                if (nw < -128) nw = -128;
                ref_w[idx][i] = nw;
                nc = -nw;
                if (nc > 127) nc = 127;
                b  = nw[7:0];
                bc = nc[7:0];
                e.data[8*i +: 8] = b;
                e.hob[3*i +: 3]  = b[7:5];
                e.hobc[3*i +: 3] = bc[7:5];
            end
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (stall) chk("stall_blocks_write", wr_en, 1'b0);
            if (wr_en) begin
                chk("write_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, mon_e.addr);
                    chk("wr_data", wr_data, mon_e.data);
                    chk("wr_hob", wr_hob, mon_e.hob);
                    chk("wr_hob_c", wr_hob_c, mon_e.hobc);
                    chk("train_count_before_write", train_count, exp_done);
                    exp_done++;
                end
                last_addr = wr_addr;
                last_hob  = wr_hob;
                last_hobc = wr_hob_c;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, wr_en, 1'b0);
        chk({tag, "_upd_ready"}, upd_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_rd_addr"}, rd_addr, 6'd0);
        chk({tag, "_train_count"}, train_count, 32'd0);
    endtask

    // releases reset at a negedge and follows the zeroing sweep; stall must not hold it
    task automatic init_sweep();
        int n = 0;
        stall = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        while (!wr_en && n < 8) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 64; k++) begin
            chk("init_wr_en", wr_en, 1'b1);
            chk("init_wr_addr", wr_addr, k);
            chk("init_wr_data", wr_data, 128'd0);
            @(negedge clk);
        end
        chk("init_end_wr_en", wr_en, 1'b0);
        chk("init_end_busy", busy, 1'b0);
        chk("init_end_upd_ready", upd_ready, 1'b1);
        stall = 1'b0;
    endtask

    task automatic send(input int idx, input logic dir, input logic [G-1:0] ghr);
        int n = 0;
        logic [31:0] pc;
        pc        = $urandom();
        pc[7:2]   = idx[5:0];
        upd_valid = 1'b1;
        upd_PC    = pc;
        upd_dir   = dir;
        upd_ghr   = ghr;
        while (!upd_ready && n < 200) begin
            saw_ready_low = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("upd_accept", upd_ready, 1'b1);
        if (upd_ready) model_accept(idx, dir, ghr);
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic preload(input int idx, input logic [8*G-1:0] row);
        byte sb;
        pl_idx = idx[5:0];
        pl_row = row;
        pl_en  = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
        for (int i = 0; i < G; i++) begin
            sb = row[8*i +: 8];
            ref_w[idx][i] = sb;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 1'b0);
        chk("expected_writes_drained", exp_q.size(), 0);
        chk("train_count_idle", train_count, exp_done);
    endtask

    initial begin
        logic [8*G-1:0] row, exp_row, tmp;
        logic [3*G-1:0] hc;
        logic [G-1:0]   gv;
        int             v;

        reset = 1'b0; upd_valid = 1'b0; upd_PC = '0; upd_dir = 1'b0; upd_ghr = '0;
        stall = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_row = '0;
        mon_en = 1'b0; saw_ready_low = 1'b0; rnd_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");

        // abandon a sweep part way, then a full sweep from index 0
        reset = 1'b1;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("init_abort");
        @(negedge clk);
        init_sweep();
        mon_en = 1'b1;

        // zero row, confident-less prediction trains every weight up
        send(4, 1'b1, 12'hFFF);
        wait_idle();
        chk("t_zero_row", mem[4], {12{8'h01}});
        chk("t_zero_addr", last_addr, 6'd4);
        chk("t_zero_hob", last_hob, 36'd0);
        chk("t_zero_hobc", last_hobc, {12{3'b111}});
        chk("t_zero_count", train_count, 32'd1);

        // saturated row: correct and confident -> no write; wrong -> all 0x7E
        preload(8, {12{8'h7F}});
        send(8, 1'b1, 12'hFFF);
        wait_idle();
        chk("t_sat_nowrite_count", train_count, 32'd1);
        send(8, 1'b0, 12'hFFF);
        wait_idle();
        chk("t_sat_row", mem[8], {12{8'h7E}});
        chk("t_sat_count", train_count, 32'd2);

        // -128 decremented stays -128; negated HOB saturates to +127
        preload(12, {80'd0, 8'h7F, 8'h80});
        send(12, 1'b0, 12'h003);
        wait_idle();
        tmp = mem[12];
        hc  = last_hobc;
        chk("t_neg_w0", tmp[7:0], 8'h80);
        chk("t_neg_w1", tmp[15:8], 8'h7E);
        chk("t_neg_w2", tmp[23:16], 8'h01);
        chk("t_neg_hobc0", hc[2:0], 3'b011);

        // same index twice back to back: second update sees the first
        gv = 12'hA5A;
        send(30, 1'b1, gv);
        send(30, 1'b1, gv);
        wait_idle();
        for (int i = 0; i < G; i++) exp_row[8*i +: 8] = gv[i] ? 8'h02 : 8'hFE;
        chk("t_same_idx_row", mem[30], exp_row);

        // back-to-back requests with a stalled first write
        saw_ready_low = 1'b0;
        fork
            begin
                send(20, 1'b1, 12'h0F0);
                send(21, 1'b0, 12'h333);
                send(22, 1'b1, 12'hC3C);
                send(23, 1'b0, 12'h001);
            end
            begin
                @(posedge clk);
                #1 stall = 1'b1;
                repeat (8) @(posedge clk);
                #1 stall = 1'b0;
            end
        join
        wait_idle();
        chk("t_backpressure_seen", saw_ready_low, 1'b1);

        // randomized rows, requests and stalls
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < G; i++) begin
                v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40)) - 20;
                row[8*i +: 8] = v[7:0];
            end
            preload(r, row);
        end
        fork
            begin
                for (int t = 0; t < 150; t++) begin
                    send($urandom_range(0, 15), 1'($urandom_range(0, 1)), G'($urandom_range(0, 4095)));
                    if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 stall = ($urandom_range(0, 3) == 0);
                end
                #1 stall = 1'b0;
            end
        join
        wait_idle();

        // reset while a stalled write is pending abandons it and restarts the sweep
        @(posedge clk);
        #1 stall = 1'b1;
        @(negedge clk);
        send(40, 1'b1, 12'hFFF);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1 chk_reset_outputs("mid_write");
        model_reset();
        @(negedge clk);
        init_sweep();
        mon_en = 1'b1;
        chk("t_reset_row40_cleared", mem[40], 96'd0);
        send(4, 1'b1, 12'hFFF);
        wait_idle();
        chk("t_after_reset_row", mem[4], {12{8'h01}});
        chk("t_after_reset_count", train_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

endmodule
